// File: rtl/jelly_fixed_sincos_multicycle_if.sv
// Stream bundle for the multicycle sin/cos CORDIC: an angle input stream
// and a cos/sin result stream, each with an optional user sideband.
// The slave modport is the core's view; master is the environment's view.
interface jelly_fixed_sincos_multicycle_if #(
   parameter int USER_WIDTH  = 0,
   parameter int ANGLE_WIDTH = 16,
   parameter int OUT_WIDTH   = 16
);

   localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;

   logic        [USER_BITS-1:0]   s_user;
   logic        [ANGLE_WIDTH-1:0] s_angle;
   logic                          s_valid;
   logic                          s_ready;

   logic        [USER_BITS-1:0]   m_user;
   logic signed [OUT_WIDTH-1:0]   m_cos;
   logic signed [OUT_WIDTH-1:0]   m_sin;
   logic                          m_valid;
   logic                          m_ready;

   modport slave (
      input  s_user,
      input  s_angle,
      input  s_valid,
      output s_ready,
      output m_user,
      output m_cos,
      output m_sin,
      output m_valid,
      input  m_ready
   );

   modport master (
      output s_user,
      output s_angle,
      output s_valid,
      input  s_ready,
      input  m_user,
      input  m_cos,
      input  m_sin,
      input  m_valid,
      output m_ready
   );

endinterface

// File: rtl/jelly_fixed_sincos_multicycle.sv
// Multicycle fixed-point CORDIC, rotation mode: one angle in (unsigned turns),
// cosine and sine out in Q(OUT_WIDTH-2). One micro-rotation per enabled clock
// on a single shared add/shift datapath. The top two angle bits select a
// quadrant that is applied after the iterations, so the CORDIC itself only
// ever sees a residual in [0, quarter turn).
module jelly_fixed_sincos_multicycle #(
   parameter int USER_WIDTH  = 0,
   parameter int ANGLE_WIDTH = 16,
   parameter int OUT_WIDTH   = 16,
   parameter int ITERATIONS  = OUT_WIDTH,
   parameter int GUARD_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           cke,
   jelly_fixed_sincos_multicycle_if.slave bus
);

   localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;
   localparam int XW        = OUT_WIDTH + GUARD_WIDTH + 1;   // x/y width
   localparam int ZW        = ANGLE_WIDTH + GUARD_WIDTH;     // residual angle width
   localparam int RW        = OUT_WIDTH + 1;                 // rounded x/y width
   localparam int STEP_W    = 6;                             // holds 0..32

   // Micro-rotation angles: Q32 table rescaled (with rounding) to ZW bits per turn.
   localparam int          T_SH_L = (ZW > 32) ? ZW - 32 : 0;
   localparam int          T_SH_R = (ZW > 32) ? 0 : 32 - ZW;
   localparam logic [63:0] T_RND  = (64'd1 << T_SH_R) >> 1;

   // Initial x = CORDIC gain compensation 0.6072529350, held as Q32 and
   // rescaled to the internal Q(OUT_WIDTH-2+GUARD_WIDTH) format.
   localparam int          K_EXP  = OUT_WIDTH - 2 + GUARD_WIDTH;
   localparam int          K_SH_L = (K_EXP > 32) ? K_EXP - 32 : 0;
   localparam int          K_SH_R = (K_EXP > 32) ? 0 : 32 - K_EXP;
   localparam logic [63:0] K_RND  = (64'd1 << K_SH_R) >> 1;
   localparam logic [63:0] K_Q32  = 64'd2608131496;
   localparam logic signed [XW-1:0] X_INIT = XW'(((K_Q32 << K_SH_L) + K_RND) >> K_SH_R);

   // Half-LSB bias for dropping the guard bits, half away from zero.
   localparam int HALF    = (1 << GUARD_WIDTH) >> 1;
   localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ITERATIONS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // atan(2^-i) / (2*pi) in Q32 turns.
   function automatic logic [31:0] atan_q32(input logic [4:0] i);
      case (i)
         5'd0:    atan_q32 = 32'h2000_0000;
         5'd1:    atan_q32 = 32'h12E4_051E;
         5'd2:    atan_q32 = 32'h09FB_385B;
         5'd3:    atan_q32 = 32'h0511_11D4;
         5'd4:    atan_q32 = 32'h028B_0D43;
         5'd5:    atan_q32 = 32'h0145_D7E1;
         5'd6:    atan_q32 = 32'h00A2_F61E;
         5'd7:    atan_q32 = 32'h0051_7C55;
         5'd8:    atan_q32 = 32'h0028_BE53;
         5'd9:    atan_q32 = 32'h0014_5F2F;
         5'd10:   atan_q32 = 32'h000A_2F98;
         5'd11:   atan_q32 = 32'h0005_17CC;
         5'd12:   atan_q32 = 32'h0002_8BE6;
         5'd13:   atan_q32 = 32'h0001_45F3;
         5'd14:   atan_q32 = 32'h0000_A2FA;
         5'd15:   atan_q32 = 32'h0000_517D;
         5'd16:   atan_q32 = 32'h0000_28BE;
         5'd17:   atan_q32 = 32'h0000_145F;
         5'd18:   atan_q32 = 32'h0000_0A30;
         5'd19:   atan_q32 = 32'h0000_0518;
         5'd20:   atan_q32 = 32'h0000_028C;
         5'd21:   atan_q32 = 32'h0000_0146;
         5'd22:   atan_q32 = 32'h0000_00A3;
         5'd23:   atan_q32 = 32'h0000_0051;
         5'd24:   atan_q32 = 32'h0000_0029;
         5'd25:   atan_q32 = 32'h0000_0014;
         5'd26:   atan_q32 = 32'h0000_000A;
         5'd27:   atan_q32 = 32'h0000_0005;
         5'd28:   atan_q32 = 32'h0000_0003;
         5'd29:   atan_q32 = 32'h0000_0001;
         5'd30:   atan_q32 = 32'h0000_0001;
         default: atan_q32 = 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [ZW-1:0] angle_step(input logic [4:0] i);
      logic [63:0] t;
      t = ((64'(atan_q32(i)) << T_SH_L) + T_RND) >> T_SH_R;
      return ZW'(t);
   endfunction

   function automatic logic signed [RW-1:0] round_guard(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] b;
      b = v + (v[XW-1] ? XW'(HALF_M1) : XW'(HALF));
      return RW'(b >>> GUARD_WIDTH);
   endfunction

   state_t                  state;
   state_t                  state_next;
   logic                    accept;

   logic                    s_ready_r;
   logic                    m_valid_r;
   logic [USER_BITS-1:0]    m_user_r;
   logic signed [OUT_WIDTH-1:0] m_cos_r;
   logic signed [OUT_WIDTH-1:0] m_sin_r;

   logic [STEP_W-1:0]       step;
   logic [1:0]              quad;
   logic [USER_BITS-1:0]    user_r;
   logic signed [XW-1:0]    x;
   logic signed [XW-1:0]    y;
   logic signed [ZW-1:0]    z;
   logic [ZW-1:0]           t_cur;

   logic signed [RW-1:0]    xr;
   logic signed [RW-1:0]    yr;
   logic signed [RW-1:0]    xn;
   logic signed [RW-1:0]    yn;
   logic signed [OUT_WIDTH-1:0] res_cos;
   logic signed [OUT_WIDTH-1:0] res_sin;

   assign accept = (state == ST_IDLE) && bus.s_valid && s_ready_r;
   assign t_cur  = angle_step(step[4:0]);

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_next; no latch inferred.
      state_next = state;
      case (state)
         ST_IDLE: if (accept)                  state_next = ST_RUN;
         ST_RUN:  if (step == LAST_STEP)       state_next = ST_DONE;
         ST_DONE: if (m_valid_r && bus.m_ready) state_next = ST_IDLE;
         default:                              state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else if (cke) begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state <= state_next;
      end
   end

   // Registered handshake flags, decoded from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
      end else if (cke) begin
         s_ready_r <= (state_next == ST_IDLE);
         m_valid_r <= (state_next == ST_DONE);
      end
   end

   // Round away guard bits and fold the quadrant back in.
   always_comb begin
      xr      = round_guard(x);
      yr      = round_guard(y);
      xn      = -xr;
      yn      = -yr;
      res_cos = OUT_WIDTH'(xr);
      res_sin = OUT_WIDTH'(yr);
      case (quad)
         2'd1: begin res_cos = OUT_WIDTH'(yn); res_sin = OUT_WIDTH'(xr); end
         2'd2: begin res_cos = OUT_WIDTH'(xn); res_sin = OUT_WIDTH'(yn); end
         2'd3: begin res_cos = OUT_WIDTH'(yr); res_sin = OUT_WIDTH'(xn); end
         default: ;
      endcase
   end

   // Shared CORDIC datapath: load on accept, one micro-rotation per step, then register result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: datapath is a handful of registers, not a memory, so it is fully reset.
         step     <= '0;
         quad     <= '0;
         user_r   <= '0;
         x        <= '0;
         y        <= '0;
         z        <= '0;
         m_cos_r  <= '0;
         m_sin_r  <= '0;
         m_user_r <= '0;
      end else if (cke) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  user_r <= bus.s_user;
                  quad   <= bus.s_angle[ANGLE_WIDTH-1 -: 2];
                  z      <= ZW'(bus.s_angle[ANGLE_WIDTH-3:0]) << GUARD_WIDTH;
                  x      <= X_INIT;
                  y      <= '0;
                  step   <= '0;
               end
            end
            ST_RUN: begin
               if (step == LAST_STEP) begin
                  m_cos_r  <= res_cos;
                  m_sin_r  <= res_sin;
                  m_user_r <= user_r;
               end else begin
                  if (!z[ZW-1]) begin
                     x <= x - (y >>> step);
                     y <= y + (x >>> step);
                     z <= z - $signed(t_cur);
                  end else begin
                     x <= x + (y >>> step);
                     y <= y - (x >>> step);
                     z <= z + $signed(t_cur);
                  end
                  step <= step + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.s_ready = s_ready_r;
   assign bus.m_valid = m_valid_r;
   assign bus.m_user  = m_user_r;
   assign bus.m_cos   = m_cos_r;
   assign bus.m_sin   = m_sin_r;

endmodule
